// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: tracks predicted branches, drives predictor updates and mispredict flush.
// Optional mispredict counter enabled by defining BRQ_MISS_COUNT_EN.
module branch_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic                     CLOCK,
  input  logic                     INIT,
  input  logic                     PRED_VALID,
  input  logic [ADDR_W-1:0]        PRED_ADDR,
  input  logic                     PRED_TAKEN,
  output logic                     PRED_READY,
  input  logic                     RES_VALID,
  input  logic                     RES_TAKEN,
  output logic                     RES_READY,
  output logic                     UPD_VALID,
  output logic [ADDR_W-1:0]        UPD_ADDR,
  output logic                     UPD_OUTCOME,
  output logic                     MISPREDICT,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic [15:0]              MISSES,
  output logic                     UNDERFLOW
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W:0]     mem_q [DEPTH];

  logic                upd_valid_q, upd_valid_d;
  logic [ADDR_W-1:0]   upd_addr_q, upd_addr_d;
  logic                upd_outcome_q, upd_outcome_d;
  logic                mispredict_q;
  logic                underflow_q, underflow_d;

  logic                pred_ready, res_ready;
  logic                push_acc, res_acc, mispredict;
  logic [ADDR_W-1:0]   head_addr;
  logic                head_taken;

  // Readies depend only on registered state, so no input-to-output path exists.
  assign pred_ready = (state_q == RUN) && (count_q != FULL);
  assign res_ready  = (state_q == RUN) && (count_q != '0);

  assign head_addr  = mem_q[rd_ptr_q][ADDR_W:1];
  assign head_taken = mem_q[rd_ptr_q][0];

  assign res_acc    = RES_VALID & res_ready;
  assign mispredict = res_acc & (RES_TAKEN != head_taken);
  // A push alongside a mispredicting resolve is on the wrong path.
  assign push_acc   = PRED_VALID & pred_ready & ~mispredict;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mispredict) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (res_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_acc, res_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    upd_valid_d   = res_acc;
    upd_addr_d    = upd_addr_q;
    upd_outcome_d = upd_outcome_q;
    if (res_acc) begin
      upd_addr_d    = head_addr;
      upd_outcome_d = RES_TAKEN;
    end
    underflow_d = underflow_q |
                  (RES_VALID && (state_q == RUN) && (count_q == '0));
  end

  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      state_q       <= RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_addr_q    <= '0;
      upd_outcome_q <= 1'b0;
      mispredict_q  <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_addr_q    <= upd_addr_d;
      upd_outcome_q <= upd_outcome_d;
      mispredict_q  <= mispredict;
      underflow_q   <= underflow_d;
    end
  end

  // Entry storage needs no reset: pointers and count define validity.
  always_ff @(posedge CLOCK) begin
    if (push_acc) mem_q[wr_ptr_q] <= {PRED_ADDR, PRED_TAKEN};
  end

`ifdef BRQ_MISS_COUNT_EN
  logic [15:0] misses_q;
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      misses_q <= '0;
    end else if (mispredict && (misses_q != 16'hFFFF)) begin
      misses_q <= misses_q + 16'd1;
    end
  end
  assign MISSES = misses_q;
`else
  assign MISSES = 16'h0000;
`endif

  assign PRED_READY  = pred_ready;
  assign RES_READY   = res_ready;
  assign UPD_VALID   = upd_valid_q;
  assign UPD_ADDR    = upd_addr_q;
  assign UPD_OUTCOME = upd_outcome_q;
  assign MISPREDICT  = mispredict_q;
  assign COUNT       = count_q;
  assign UNDERFLOW   = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed scoreboard bench for branch_resolve_queue (DEPTH 4, ADDR_W 3).
module tb_branch_resolve_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic              CLOCK = 1'b0;
  logic              INIT = 1'b1;
  logic              PRED_VALID = 1'b0;
  logic [ADDR_W-1:0] PRED_ADDR = '0;
  logic              PRED_TAKEN = 1'b0;
  logic              PRED_READY;
  logic              RES_VALID = 1'b0;
  logic              RES_TAKEN = 1'b0;
  logic              RES_READY;
  logic              UPD_VALID;
  logic [ADDR_W-1:0] UPD_ADDR;
  logic              UPD_OUTCOME;
  logic              MISPREDICT;
  logic [2:0]        COUNT;
  logic [15:0]       MISSES;
  logic              UNDERFLOW;

  branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLOCK(CLOCK), .INIT(INIT),
    .PRED_VALID(PRED_VALID), .PRED_ADDR(PRED_ADDR), .PRED_TAKEN(PRED_TAKEN),
    .PRED_READY(PRED_READY),
    .RES_VALID(RES_VALID), .RES_TAKEN(RES_TAKEN), .RES_READY(RES_READY),
    .UPD_VALID(UPD_VALID), .UPD_ADDR(UPD_ADDR), .UPD_OUTCOME(UPD_OUTCOME),
    .MISPREDICT(MISPREDICT), .COUNT(COUNT), .MISSES(MISSES),
    .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct { logic [ADDR_W-1:0] addr; logic taken; } ent_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic outcome; logic mis; } upd_t;

  ent_t m_q[$];
  upd_t exp_q[$];
  bit   m_flush;
  bit   m_uf;
  int   m_miss;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_misses();
`ifdef BRQ_MISS_COUNT_EN
    return (m_miss > 16'hFFFF) ? 32'hFFFF : 32'(m_miss);
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_all(input string tag);
    upd_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".upd_valid"},   32'(UPD_VALID),   32'h1);
      chk({tag, ".upd_addr"},    32'(UPD_ADDR),    32'(e.addr));
      chk({tag, ".upd_outcome"}, 32'(UPD_OUTCOME), 32'(e.outcome));
      chk({tag, ".mispredict"},  32'(MISPREDICT),  32'(e.mis));
    end else begin
      chk({tag, ".upd_valid"},  32'(UPD_VALID),  32'h0);
      chk({tag, ".mispredict"}, 32'(MISPREDICT), 32'h0);
    end
    chk({tag, ".count"},      32'(COUNT),      32'(m_q.size()));
    chk({tag, ".pred_ready"}, 32'(PRED_READY), 32'(!m_flush && m_q.size() != DEPTH));
    chk({tag, ".res_ready"},  32'(RES_READY),  32'(!m_flush && m_q.size() != 0));
    chk({tag, ".underflow"},  32'(UNDERFLOW),  32'(m_uf));
    chk({tag, ".misses"},     32'(MISSES),     exp_misses());
  endtask

  // One clock: drive, advance the reference model, then check after the edge.
  task automatic cyc(input string tag, input bit pv, input logic [ADDR_W-1:0] pa,
                     input bit pt, input bit rv, input bit rt);
    bit   push, pop, mis;
    ent_t e;
    upd_t u;
    PRED_VALID = pv; PRED_ADDR = pa; PRED_TAKEN = pt;
    RES_VALID = rv;  RES_TAKEN = rt;
    push = pv && !m_flush && (m_q.size() != DEPTH);
    pop  = rv && !m_flush && (m_q.size() != 0);
    if (rv && !m_flush && m_q.size() == 0) m_uf = 1'b1;
    mis = 1'b0;
    if (pop) begin
      e = m_q.pop_front();
      mis = (e.taken != rt);
      u.addr = e.addr; u.outcome = rt; u.mis = mis;
      exp_q.push_back(u);
    end
    if (mis) begin
      m_q.delete();
      m_miss++;
      m_flush = 1'b1;
    end else begin
      m_flush = 1'b0;
      if (push) begin
        e.addr = pa; e.taken = pt;
        m_q.push_back(e);
      end
    end
    @(posedge CLOCK); #1;
    PRED_VALID = 1'b0; RES_VALID = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input int n, input bit rv);
    INIT = 1'b1; PRED_VALID = 1'b0; RES_VALID = rv; RES_TAKEN = 1'b1;
    repeat (n) @(posedge CLOCK);
    #1;
    RES_VALID = 1'b0;
    m_q.delete(); exp_q.delete();
    m_flush = 1'b0; m_uf = 1'b0; m_miss = 0;
    check_all("reset");
    chk("reset.upd_addr", 32'(UPD_ADDR), 32'h0);
    chk("reset.upd_outcome", 32'(UPD_OUTCOME), 32'h0);
    INIT = 1'b0;
  endtask

  initial begin
    m_flush = 1'b0; m_uf = 1'b0; m_miss = 0;
    do_reset(2, 1'b0);

    // In-order correct predictions
    cyc("p1", 1, 3'd1, 0, 0, 0);
    cyc("p2", 1, 3'd1, 0, 0, 0);
    cyc("p3", 1, 3'd2, 1, 0, 0);
    cyc("r1", 0, 3'd0, 0, 1, 0);
    cyc("r2", 0, 3'd0, 0, 1, 0);
    cyc("r3", 0, 3'd0, 0, 1, 1);
    cyc("idle1", 0, 3'd0, 0, 0, 0);

    // Fill, stall, resolve with push at full and below full
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 3'(i), 0, 0, 0);
    cyc("stall", 1, 3'd7, 0, 0, 0);
    cyc("full_rp", 1, 3'd6, 0, 1, 0);
    cyc("part_rp", 1, 3'd5, 1, 1, 0);
    for (int i = 0; i < DEPTH; i++) cyc("drain", 0, 3'd0, 0, 1, (i == DEPTH - 1));
    cyc("idle2", 0, 3'd0, 0, 0, 0);

    // Mispredict and flush
    cyc("m_p1", 1, 3'd1, 1, 0, 0);
    cyc("m_p2", 1, 3'd2, 1, 0, 0);
    cyc("m_p3", 1, 3'd3, 0, 0, 0);
    cyc("m_res", 0, 3'd0, 0, 1, 0);
    cyc("m_flush", 1, 3'd4, 0, 0, 0);
    cyc("m_after", 0, 3'd0, 0, 0, 0);

    // Mispredict with concurrent wrong-path push
    cyc("w_p", 1, 3'd4, 1, 0, 0);
    cyc("w_res", 1, 3'd5, 1, 1, 0);
    cyc("w_flush", 0, 3'd0, 0, 0, 0);
    cyc("w_after", 0, 3'd0, 0, 0, 0);

    // Underflow, then pointer wrap
    cyc("uf", 0, 3'd0, 0, 1, 1);
    cyc("uf_hold", 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc("wrap_p", 1, 3'(i), (i % 3 == 0), 0, 0);
      cyc("wrap_r", 0, 3'd0, 0, 1, (i % 3 == 0));
    end
    cyc("idle3", 0, 3'd0, 0, 0, 0);

    // Reset mid-operation cancels a pending resolve
    cyc("i_p1", 1, 3'd6, 1, 0, 0);
    cyc("i_p2", 1, 3'd7, 0, 0, 0);
    do_reset(1, 1'b1);
    cyc("post", 1, 3'd3, 1, 0, 0);
    cyc("post_r", 0, 3'd0, 0, 1, 1);
    cyc("idle4", 0, 3'd0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
